// File: rtl/clock_display_scan.sv
`timescale 1ns/1ps
// clock_display_scan
//
// Purpose: multiplexes the alarm clock's BCD time onto a 4-digit
// common-anode 7-segment display. One digit is lit at a time. Each digit
// slot starts with a short all-anodes-off gap so the previous digit's
// segments never show under the next anode. The hour/minute separator
// (dp on the hour-units digit) blinks with seconds[0]. The five data
// inputs are sampled once per frame, so a digit never changes part way
// through a frame.
//
// Ports:
//   clock       in   1  system clock
//   reset_n     in   1  asynchronous active-low reset
//   hour_in1    in   2  hour tens digit (0-2)
//   hour_in0    in   4  hour units digit (0-9)
//   minute_in1  in   4  minute tens digit (0-5)
//   minute_in0  in   4  minute units digit (0-9)
//   seconds     in   6  binary seconds (0-59); only the LSB is displayed
//   alarm       in   1  alarm active (level)
//   an          out  4  anode enables, active-low; an[3]=hour tens .. an[0]=minute units
//   seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal point, active-low
//
// Build option: define ALARM_FLASH_EN to flash the whole display while
// alarm is high. Without it the alarm port is present but ignored.

module clock_display_scan #(
  parameter int CLK_HZ    = 100000000,
  parameter int SCAN_HZ   = 1000,
  parameter int GHOST_CYC = 16,
  parameter int BLINK_HZ  = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] hour_in1,
  input  logic [3:0] hour_in0,
  input  logic [3:0] minute_in1,
  input  logic [3:0] minute_in0,
  input  logic [5:0] seconds,
  input  logic       alarm,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] GHOST_LIM  = DW'(GHOST_CYC);

  // Digit slot being scanned; the encoding equals the anode bit position.
  typedef enum logic [1:0] {
    DIG_MIN0  = 2'd0,
    DIG_MIN1  = 2'd1,
    DIG_HOUR0 = 2'd2,
    DIG_HOUR1 = 2'd3
  } digit_e;

  logic [DW-1:0] dwell_q, dwell_d;
  digit_e        idx_q, idx_d;

  logic [1:0] hour1_sh_q, hour1_sh_d;
  logic [3:0] hour0_sh_q, hour0_sh_d;
  logic [3:0] min1_sh_q, min1_sh_d;
  logic [3:0] min0_sh_q, min0_sh_d;
  logic       sec0_sh_q, sec0_sh_d;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic [3:0] digit_val;
  logic       flash_off;

  // Active-low segment patterns; anything above 9 shows a dash so a bad
  // BCD value from the clock core is visible rather than silently wrong.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

`ifdef ALARM_FLASH_EN
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_on_q, phase_on_d;
  logic          alarm_prev_q, alarm_prev_d;

  // Flash phase timer. A fresh alarm always starts in the visible phase;
  // with the alarm idle the timer is parked so the next alarm starts clean.
  always_comb begin
    blink_cnt_d  = blink_cnt_q;
    phase_on_d   = phase_on_q;
    alarm_prev_d = alarm;
    if (!alarm || !alarm_prev_q) begin
      blink_cnt_d = '0;
      phase_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_on_d  = ~phase_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q  <= '0;
      phase_on_q   <= 1'b1;
      alarm_prev_q <= 1'b0;
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      phase_on_q   <= phase_on_d;
      alarm_prev_q <= alarm_prev_d;
    end
  end

  // Gated by the live alarm level so dropping the alarm restores the
  // display on the very next registered output.
  assign flash_off = alarm & ~phase_on_q;
`else
  assign flash_off = 1'b0;
`endif

  // Dwell counter, digit index and frame shadow. The shadow loads only on
  // the 3->0 index wrap so every frame shows one consistent time.
  always_comb begin
    dwell_d    = dwell_q + DW'(1);
    idx_d      = idx_q;
    hour1_sh_d = hour1_sh_q;
    hour0_sh_d = hour0_sh_q;
    min1_sh_d  = min1_sh_q;
    min0_sh_d  = min0_sh_q;
    sec0_sh_d  = sec0_sh_q;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      case (idx_q)
        DIG_MIN0:  idx_d = DIG_MIN1;
        DIG_MIN1:  idx_d = DIG_HOUR0;
        DIG_HOUR0: idx_d = DIG_HOUR1;
        default:   idx_d = DIG_MIN0;
      endcase
      if (idx_q == DIG_HOUR1) begin
        hour1_sh_d = hour1_in_cap();
        hour0_sh_d = hour0_in_cap();
        min1_sh_d  = minute_in1;
        min0_sh_d  = minute_in0;
        sec0_sh_d  = seconds[0];
      end
    end
  end

  function automatic logic [1:0] hour1_in_cap();
    return hour_in1;
  endfunction

  function automatic logic [3:0] hour0_in_cap();
    return hour_in0;
  endfunction

  // Next registered display value. seg/dp switch to the new digit at the
  // start of the slot; only the anodes are held off during the ghost gap.
  always_comb begin
    case (idx_q)
      DIG_MIN0:  digit_val = min0_sh_q;
      DIG_MIN1:  digit_val = min1_sh_q;
      DIG_HOUR0: digit_val = hour0_sh_q;
      default:   digit_val = {2'b00, hour1_sh_q};
    endcase
    seg_d = seg_decode(digit_val);
    an_d  = 4'b1111;
    dp_d  = 1'b1;
    if (idx_q == DIG_HOUR0 && !sec0_sh_q) begin
      dp_d = 1'b0;
    end
    if (dwell_q >= GHOST_LIM) begin
      an_d = ~(4'b0001 << idx_q);
    end
    if (idx_q == DIG_HOUR1 && hour1_sh_q == 2'd0) begin
      an_d = 4'b1111;
    end
    if (flash_off) begin
      an_d = 4'b1111;
      dp_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q    <= '0;
      idx_q      <= DIG_MIN0;
      hour1_sh_q <= '0;
      hour0_sh_q <= '0;
      min1_sh_q  <= '0;
      min0_sh_q  <= '0;
      sec0_sh_q  <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      dwell_q    <= dwell_d;
      idx_q      <= idx_d;
      hour1_sh_q <= hour1_sh_d;
      hour0_sh_q <= hour0_sh_d;
      min1_sh_q  <= min1_sh_d;
      min0_sh_q  <= min0_sh_d;
      sec0_sh_q  <= sec0_sh_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
`timescale 1ns/1ps
// Directed testbench for clock_display_scan with a 10-cycle digit slot
// (2 ghost cycles + 8 lit), a 40-cycle frame and a 20-cycle flash phase.
// "cyc" counts clock edges since reset release, so edge n belongs to slot
// ((n-1)/10)%4 at position (n-1)%10, and frame f covers edges 40f+1..40f+40
// using the inputs present at edge 40f.

module tb_clock_display_scan;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] hour_in1 = '0;
  logic [3:0] hour_in0 = '0;
  logic [3:0] minute_in1 = '0;
  logic [3:0] minute_in0 = '0;
  logic [5:0] seconds = '0;
  logic       alarm = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad = 0;
  int cyc;

  logic [3:0] dig [4];
  bit         blank3;
  bit         sec0;

  clock_display_scan #(
    .CLK_HZ(1000), .SCAN_HZ(100), .GHOST_CYC(2), .BLINK_HZ(25)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .hour_in1(hour_in1), .hour_in0(hour_in0),
    .minute_in1(minute_in1), .minute_in0(minute_in0),
    .seconds(seconds), .alarm(alarm),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic int slot_idx(input int n);
    return ((n - 1) / 10) % 4;
  endfunction

  function automatic logic [3:0] scan_an(input int n, input bit b3);
    int p;
    int i;
    p = (n - 1) % 10;
    i = slot_idx(n);
    if (p < 2) return 4'b1111;
    if (i == 3 && b3) return 4'b1111;
    case (i)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    int i;
    reset_n = 1'b0;
    hour_in1 = 2'd1; hour_in0 = 4'd2; minute_in1 = 4'd3; minute_in0 = 4'd4;
    seconds = 6'd0; alarm = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (an !== 4'hF) begin bad++; $display("[TB] FAIL reset_an got=%h exp=F", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("[TB] FAIL reset_seg got=%h exp=7F", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("[TB] FAIL reset_dp got=%b exp=1", dp); end
    reset_n = 1'b1;
    dig = '{4'd0, 4'd0, 4'd0, 4'd0}; blank3 = 1'b1; sec0 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      i = slot_idx(cyc);
      total++; if (an !== scan_an(cyc, blank3)) begin bad++; $display("[TB] FAIL first_frame_an n=%0d got=%h exp=%h", cyc, an, scan_an(cyc, blank3)); end
      total++; if (seg !== dec(dig[i])) begin bad++; $display("[TB] FAIL first_frame_seg n=%0d got=%h exp=%h", cyc, seg, dec(dig[i])); end
      total++; if (dp !== ((i == 2 && !sec0) ? 1'b0 : 1'b1)) begin bad++; $display("[TB] FAIL first_frame_dp n=%0d got=%b", cyc, dp); end
    end
  endtask

  task automatic test_ghost_and_digits();
    int i;
    dig = '{4'd4, 4'd3, 4'd2, 4'd1}; blank3 = 1'b0; sec0 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      i = slot_idx(cyc);
      total++; if (an !== scan_an(cyc, blank3)) begin bad++; $display("[TB] FAIL ghost_an n=%0d got=%h exp=%h", cyc, an, scan_an(cyc, blank3)); end
      total++; if (seg !== dec(dig[i])) begin bad++; $display("[TB] FAIL digit_seg n=%0d got=%h exp=%h", cyc, seg, dec(dig[i])); end
      total++; if (dp !== ((i == 2 && !sec0) ? 1'b0 : 1'b1)) begin bad++; $display("[TB] FAIL digit_dp n=%0d got=%b", cyc, dp); end
    end
  endtask

  task automatic test_tearing_blank_error();
    int i;
    for (int f = 0; f < 3; f++) begin
      case (f)
        0: begin dig = '{4'd4, 4'd3, 4'd2, 4'd1}; blank3 = 1'b0; end
        1: begin dig = '{4'd7, 4'd3, 4'd2, 4'd0}; blank3 = 1'b1; end
        default: begin dig = '{4'd12, 4'd3, 4'd2, 4'd0}; blank3 = 1'b1; end
      endcase
      for (int k = 0; k < 40; k++) begin
        step();
        i = slot_idx(cyc);
        total++; if (an !== scan_an(cyc, blank3)) begin bad++; $display("[TB] FAIL tear_an n=%0d got=%h exp=%h", cyc, an, scan_an(cyc, blank3)); end
        total++; if (seg !== dec(dig[i])) begin bad++; $display("[TB] FAIL tear_seg n=%0d got=%h exp=%h", cyc, seg, dec(dig[i])); end
        total++; if (dp !== ((i == 2 && !sec0) ? 1'b0 : 1'b1)) begin bad++; $display("[TB] FAIL tear_dp n=%0d got=%b", cyc, dp); end
        if (cyc == 85) begin minute_in0 = 4'd7; hour_in1 = 2'd0; end
        if (cyc == 125) minute_in0 = 4'd12;
      end
    end
  endtask

  task automatic test_separator();
    int i;
    seconds = 6'd1;
    for (int f = 0; f < 3; f++) begin
      sec0 = (f == 1);
      if (f == 1) seconds = 6'd58;
      for (int k = 0; k < 40; k++) begin
        step();
        i = slot_idx(cyc);
        total++; if (an !== scan_an(cyc, blank3)) begin bad++; $display("[TB] FAIL sep_an n=%0d got=%h exp=%h", cyc, an, scan_an(cyc, blank3)); end
        total++; if (seg !== dec(dig[i])) begin bad++; $display("[TB] FAIL sep_seg n=%0d got=%h exp=%h", cyc, seg, dec(dig[i])); end
        total++; if (dp !== ((i == 2 && !sec0) ? 1'b0 : 1'b1)) begin bad++; $display("[TB] FAIL sep_dp n=%0d got=%b sec0=%0d", cyc, dp, sec0); end
      end
    end
  endtask

`ifdef ALARM_FLASH_EN
  task automatic test_flash();
    int n0;
    int m;
    int i;
    bit off;
    n0 = cyc;
    alarm = 1'b1;
    for (int k = 0; k < 65; k++) begin
      step();
      m = cyc - n0 - 1;
      i = slot_idx(cyc);
      off = (m >= 1) && (((m - 1) / 20) % 2 == 1);
      total++; if (an !== (off ? 4'hF : scan_an(cyc, blank3))) begin bad++; $display("[TB] FAIL flash_an m=%0d got=%h off=%0d", m, an, off); end
      total++; if (dp !== ((!off && i == 2 && !sec0) ? 1'b0 : 1'b1)) begin bad++; $display("[TB] FAIL flash_dp m=%0d got=%b off=%0d", m, dp, off); end
    end
    alarm = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if (an !== scan_an(cyc, blank3)) begin bad++; $display("[TB] FAIL flash_resume_an n=%0d got=%h exp=%h", cyc, an, scan_an(cyc, blank3)); end
    end
  endtask
`else
  task automatic test_macro_off();
    int i;
    alarm = 1'b1;
    for (int k = 0; k < 65; k++) begin
      step();
      i = slot_idx(cyc);
      total++; if (an !== scan_an(cyc, blank3)) begin bad++; $display("[TB] FAIL noflash_an n=%0d got=%h exp=%h", cyc, an, scan_an(cyc, blank3)); end
      total++; if (dp !== ((i == 2 && !sec0) ? 1'b0 : 1'b1)) begin bad++; $display("[TB] FAIL noflash_dp n=%0d got=%b", cyc, dp); end
    end
    alarm = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if (an !== scan_an(cyc, blank3)) begin bad++; $display("[TB] FAIL noflash_resume_an n=%0d got=%h exp=%h", cyc, an, scan_an(cyc, blank3)); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int guard;
    int i;
    guard = 0;
    while (!(slot_idx(cyc) == 2 && (cyc - 1) % 10 == 5) && guard < 50) begin
      step();
      guard++;
    end
    total++;
    if (guard >= 50) begin
      bad++; $display("[TB] FAIL reset_mid_seek got=timeout exp=slot2");
    end
    total++; if (an !== 4'b1011) begin bad++; $display("[TB] FAIL reset_mid_pre_an got=%h exp=B", an); end
    reset_n = 1'b0;
    #1;
    total++; if (an !== 4'hF) begin bad++; $display("[TB] FAIL reset_mid_an got=%h exp=F", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("[TB] FAIL reset_mid_seg got=%h exp=7F", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("[TB] FAIL reset_mid_dp got=%b exp=1", dp); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    dig = '{4'd0, 4'd0, 4'd0, 4'd0}; blank3 = 1'b1; sec0 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      i = slot_idx(cyc);
      total++; if (an !== scan_an(cyc, blank3)) begin bad++; $display("[TB] FAIL restart_an n=%0d got=%h exp=%h", cyc, an, scan_an(cyc, blank3)); end
      total++; if (seg !== dec(dig[i])) begin bad++; $display("[TB] FAIL restart_seg n=%0d got=%h exp=%h", cyc, seg, dec(dig[i])); end
    end
  endtask

  initial begin
    test_reset();
    test_ghost_and_digits();
    test_tearing_blank_error();
    test_separator();
`ifdef ALARM_FLASH_EN
    test_flash();
`else
    test_macro_off();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

- Drives a 4-digit common-anode 7-segment display from the alarm clock's BCD time outputs.
- Digit order: hour tens, hour units, minute tens, minute units.
- Multiplexes one digit at a time, with an anti-ghosting blank gap between digits.
- Blinks the hour/minute separator from the seconds count and flashes the whole display while the alarm is active.
- Sits between the alarm clock core and the board's anode, segment and dp pins.

## Interface

Parameters:
- CLK_HZ, 100000000: input clock frequency.
- SCAN_HZ, 1000: per-digit dwell rate; SCAN_DIV = CLK_HZ/SCAN_HZ cycles per digit.
- GHOST_CYC, 16: cycles with all anodes off at the start of each digit slot; must be < SCAN_DIV.
- BLINK_HZ, 2: alarm flash rate; BLINK_DIV = CLK_HZ/(2*BLINK_HZ) cycles per phase.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- hour_in1  in  2  hour tens digit, 0-2.
- hour_in0  in  4  hour units digit, 0-9.
- minute_in1  in  4  minute tens digit, 0-5.
- minute_in0  in  4  minute units digit, 0-9.
- seconds  in  6  binary seconds, 0-59.
- alarm  in  1  alarm active, level.
- an  out  4  anode enables, active-low; an[3] = hour tens … an[0] = minute units.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation

- **Dwell counter:** counts 0..SCAN_DIV-1 and wraps. At the terminal count, the digit index advances 0→1→2→3→0.
- **Digit index mapping:** 0 = minute_in0, 1 = minute_in1, 2 = hour_in0, 3 = hour_in1.
- **Frame shadow:** all five data inputs are captured into a shadow register only on the cycle the index wraps 3→0. Digits are never torn mid-frame. Shadow resets to 0.
- **Decode (shadow digit):**
  - 0:40h, 1:79h, 2:24h, 3:30h, 4:19h, 5:12h, 6:02h, 7:78h, 8:00h, 9:10h.
  - Values 10-15 decode to 3Fh (dash, error indication).
- **Leading-zero blank:** digit 3 with shadow hour tens = 0 drives an[3]=1 for its whole slot.
- **Separator:** dp=0 only during the digit-2 slot when shadow seconds[0]=0; otherwise dp=1.
- **Ghost gap:** while the dwell count < GHOST_CYC, an=4'b1111. seg and dp already carry the new digit's value.
- **Flash:** see Configuration. During the flash-off phase an=4'b1111 and dp=1.

## Timing

- **Reset values:** an=4'b1111, seg=7Fh, dp=1, dwell=0, index=0, blink counter=0, flash phase=on.
- **Output registering:** an, seg and dp are registered, with 1 cycle latency from the dwell/index/shadow state.
- **First frame after reset:** displays the shadow (all zero) until the first 3→0 wrap, i.e. 4·SCAN_DIV cycles.
- **Input latency:** the shadow updates on the wrap cycle and is visible on seg starting with the next registered output. Worst-case input-to-display latency is 4·SCAN_DIV+1 cycles.
- **Reset mid-frame:** asserting reset_n returns all outputs to their reset values within the same cycle (asynchronous). Scanning restarts at index 0 after deassertion.
- **Input changes mid-frame:** ignored until the next wrap.
- **Simultaneous wrap and alarm edge:** the shadow captures as normal; flash phase handling is independent of scanning.

## Configuration

- **ALARM_FLASH_EN defined:**
  - A blink counter runs 0..BLINK_DIV-1 while alarm=1.
  - The flash phase toggles at each terminal count.
  - A rising edge of alarm (registered previous value) clears the counter and forces phase=on, so the display is visibly on first.
  - alarm=0 holds the counter at 0 and phase=on.
- **ALARM_FLASH_EN undefined:**
  - The alarm input is ignored; no blink logic is synthesized.
  - The display is never flashed. The port remains present.

## Test plan

All scenarios use bench parameters CLK_HZ=1000, SCAN_HZ=100 (SCAN_DIV=10), GHOST_CYC=2, BLINK_HZ=25 (BLINK_DIV=20).

- **Reset and first frame:** hold reset_n=0 for 3 cycles, then release with inputs 1,2,3,4, seconds=0.
  - During reset: an=F, seg=7Fh, dp=1.
  - First 40 cycles show 0 on digits 0-2 and an[3] stays 1.
  - After the wrap: digit 3 seg=79h, digit 2 seg=24h with dp=0, digit 1 seg=30h, digit 0 seg=19h.
- **Ghost gap:** on each slot, an=F for exactly 2 cycles, then a single 0 bit for 8 cycles at the slot's position.
- **Tearing, blanking and error decode:** change minute_in0 from 4 to 7 mid-frame.
  - seg stays 19h in slot 0 until the next frame, then shows 78h.
  - hour_in1=0 keeps an[3]=1 for the whole slot.
  - minute_in0=12 shows 3Fh.
- **Separator:** seconds=1 → dp=1 in all slots. seconds=58 → dp=0 only in slot 2.
- **Flash (ALARM_FLASH_EN defined):** raise alarm.
  - an follows the scan for 20 cycles, then stays F for 20 cycles, repeating.
  - Drop alarm mid-off-phase → scanning resumes within 1 cycle.
- **Macro off:** the same alarm stimulus leaves the scan pattern unchanged.
- **Reset mid-operation:** pulse reset_n low during slot 2 → an=F and seg=7Fh immediately; after release, index 0 is shown with shadow=0.
